// File: rtl/shifter_iter.sv
// Multi-cycle shift/rotate unit: applies up to STEP bit positions per clock
// with a start/busy/done handshake and a synchronous kill for flushes.
module shifter_iter #(
  parameter int XLEN = 32,
  parameter int STEP = 1,
  localparam int SHW = $clog2(XLEN)
) (
  input  logic            i_clk_n,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_in_a,
  input  logic [SHW-1:0]  i_in_b,
  input  logic            i_kill,
  output logic [XLEN-1:0] o_result,
  output logic            o_busy,
  output logic            o_done
);

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  // One extra bit so that STEP == XLEN is representable.
  localparam logic [SHW:0] STEP_W = (SHW+1)'(STEP);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state_reg, state_next;
  logic [XLEN-1:0]   result_reg;
  logic [SHW-1:0]    remaining_reg;
  logic [2:0]        op_reg;

  logic              accept;
  logic              zero_op;
  logic              last_step;
  logic [SHW:0]      rem_ext;
  logic [SHW:0]      step_d;
  logic [SHW-1:0]    remaining_next;
  logic [2*XLEN-1:0] rot_l;
  logic [2*XLEN-1:0] rot_r;
  logic [XLEN-1:0]   shifted;

  assign accept  = i_start && !i_kill && (state_reg != SHIFT);
  // Reserved opcodes are treated as a zero-distance operation.
  assign zero_op = (i_in_b == '0) || (i_op > OP_ROR);

  always_comb begin
    rem_ext        = {1'b0, remaining_reg};
    last_step      = (rem_ext <= STEP_W);
    step_d         = last_step ? rem_ext : STEP_W;
    remaining_next = last_step ? '0 : remaining_reg - STEP_W[SHW-1:0];
    rot_l          = {result_reg, result_reg} << step_d;
    rot_r          = {result_reg, result_reg} >> step_d;
    case (op_reg)
      OP_SLL:  shifted = result_reg << step_d;
      OP_SRL:  shifted = result_reg >> step_d;
      OP_SRA:  shifted = $unsigned($signed(result_reg) >>> step_d);
      OP_ROL:  shifted = rot_l[2*XLEN-1:XLEN];
      OP_ROR:  shifted = rot_r[XLEN-1:0];
      default: shifted = result_reg;
    endcase
  end

  always_ff @(posedge i_clk_n or posedge i_rst) begin
    if (i_rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (i_kill) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        SHIFT:   state_next = last_step ? DONE : SHIFT;
        default: state_next = accept ? (zero_op ? DONE : SHIFT) : IDLE;
      endcase
    end
  end

  always_comb begin
    o_busy = (state_reg == SHIFT);
    o_done = (state_reg == DONE);
  end

  // Kill leaves the partial result visible but clears the pending distance.
  always_ff @(posedge i_clk_n or posedge i_rst) begin
    if (i_rst) begin
      result_reg    <= '0;
      remaining_reg <= '0;
      op_reg        <= OP_SLL;
    end else if (i_kill) begin
      remaining_reg <= '0;
    end else if (accept) begin
      result_reg    <= i_in_a;
      remaining_reg <= zero_op ? '0 : i_in_b;
      op_reg        <= i_op;
    end else if (state_reg == SHIFT) begin
      result_reg    <= shifted;
      remaining_reg <= remaining_next;
    end
  end

  assign o_result = result_reg;

endmodule

// File: doc/shifter_iter.md
Name: shifter_iter

Overview:
- Parametrised multi-cycle shift/rotate unit. It is the next-generation replacement for the execute-stage shifter.
- Generalised in data width (XLEN) and in shift distance per clock (STEP), which trades area against latency.
- Adds rotate operations (rol/ror), an explicit start/done handshake and a synchronous kill for pipeline flushes.
- Sits beside the ALU. The pipeline stalls on o_busy and captures o_result on o_done.

Parameters:
- XLEN, 32, datapath width. Legal values: 32 or 64.
- STEP, 1, maximum shift distance applied per clock. Power of two, 1..XLEN. STEP=XLEN makes every op complete in one shift cycle.
- Derived localparam SHW = log2(XLEN), the shift-amount width.

Ports:
- i_clk_n  in  1  clock; all state updates on its rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_start  in  1  request; sampled only when not busy
- i_op  in  3  000 sll, 001 srl, 010 sra, 011 rol, 100 ror; 101-111 reserved
- i_in_a  in  XLEN  operand to shift
- i_in_b  in  SHW  shift amount; upper operand bits are already stripped by the caller
- i_kill  in  1  synchronous abort of the current op
- o_result  out  XLEN  result register
- o_busy  out  1  high while an op is in progress
- o_done  out  1  one-cycle pulse; o_result is valid while it is high

Behaviour:
- Reset (asynchronous, any time, including mid-operation): state=IDLE, o_result=0, remaining=0, o_busy=0, o_done=0.
- States: IDLE, SHIFT, DONE.
  - o_busy = (state==SHIFT).
  - o_done = (state==DONE).
- Accept: in IDLE or DONE, i_start=1 and i_kill=0 at edge t0 latches:
  - o_result <= i_in_a
  - remaining <= i_in_b
  - op <= i_op
  - Next state is DONE if i_in_b==0, else SHIFT.
- SHIFT, each edge:
  - d = min(STEP, remaining)
  - o_result <= op(o_result, d)
  - remaining <= remaining - d
  - When remaining <= STEP this is the last shift and the next state is DONE.
- Latency: N = ceil(shamt/STEP). o_done is high in the cycle after edge t0+N (N=0 gives a 1-cycle latency).
- Ops on each step:
  - sll: fill zeros.
  - srl: fill zeros.
  - sra: fill with bit XLEN-1 of the current o_result. This equals the original sign because sign bits are preserved.
  - rol/ror: rotate by d, so the cumulative rotation equals shamt mod XLEN.
- Reserved i_op: accepted as a zero-distance op. o_result=i_in_a, o_done after 1 cycle.
- DONE lasts exactly one cycle. It returns to IDLE unless a new start is accepted in that same cycle, in which case back-to-back ops are allowed.
- o_result holds its value in IDLE until the next accept.
- i_start while in SHIFT: ignored, with no effect on the running op. The caller must hold the request until o_busy is low.
- i_kill=1 at any edge:
  - Next state is IDLE and remaining=0.
  - o_result keeps its current (partial) value.
  - No o_done is produced for the killed op.
  - Kill has priority over a simultaneous i_start; that start is dropped.
- Inputs i_in_a/i_in_b/i_op are only sampled at accept. Changing them while busy has no effect.
- No combinational path from inputs to outputs.

Test Plan:
- XLEN=32, STEP=4: sra, a=0x80000000, b=7 -> N=2; o_busy high 2 cycles; o_done in cycle t0+2 with o_result=0xFF000000.
- XLEN=32, STEP=1: sll, a=0x00000001, b=31 -> o_busy high 31 cycles; o_done once with o_result=0x80000000. A second i_start issued mid-op is ignored and the result is unchanged.
- XLEN=32, STEP=4: ror, a=0x00000001, b=1 -> 0x80000000 after 1 shift. Then srl a=0xDEADBEEF, b=0 -> o_done in the next cycle, o_busy never high, o_result=0xDEADBEEF.
- XLEN=64, STEP=8: rol, a=0x0123456789ABCDEF, b=8 -> o_result=0x23456789ABCDEF01 with N=1. Back-to-back start in the DONE cycle (srl by 4) -> 0x023456789ABCDEF0.
- Kill/reset: start sll b=20 with STEP=1, assert i_kill at shift 5 -> IDLE, no o_done. Start again with i_kill and i_start high together -> dropped. Assert i_rst mid-op (asynchronous, between edges) -> all outputs 0 immediately.
- Reserved i_op=111, a=0x12345678, b=9 -> o_done after 1 cycle with o_result=0x12345678.
